// File: rtl/tpg_pkg.sv
// Shared definitions for the test pattern generator: default geometry,
// pattern-select encodings and the colour-bar palette.
package tpg_pkg;

    localparam int unsigned DEF_CW         = 8;
    localparam int unsigned DEF_H_OFFSET   = 216;
    localparam int unsigned DEF_H_ACTIVE   = 800;
    localparam int unsigned DEF_V_OFFSET   = 35;
    localparam int unsigned DEF_BAR_W      = 100;
    localparam int unsigned DEF_BAR_H      = 60;
    localparam int unsigned DEF_CHK_LOG2   = 5;
    localparam int unsigned DEF_SCROLL_DIV = 4;

    localparam int unsigned BAR_IDX_W = 3;
    typedef logic [BAR_IDX_W-1:0] bar_idx_t;

    typedef enum logic [2:0] {
        MODE_VBAR     = 3'd0,
        MODE_HBAR     = 3'd1,
        MODE_CHECKER  = 3'd2,
        MODE_GRADIENT = 3'd3,
        MODE_WHITE    = 3'd4,
        MODE_BLACK5   = 3'd5,
        MODE_BLACK6   = 3'd6,
        MODE_BLACK7   = 3'd7
    } tpg_mode_e;

    // Palette entries as {R,G,B} on/off flags; expanded to CW bits by the user.
    localparam logic [2:0] PAL_WHITE   = 3'b111;
    localparam logic [2:0] PAL_YELLOW  = 3'b110;
    localparam logic [2:0] PAL_CYAN    = 3'b011;
    localparam logic [2:0] PAL_GREEN   = 3'b010;
    localparam logic [2:0] PAL_MAGENTA = 3'b101;
    localparam logic [2:0] PAL_RED     = 3'b100;
    localparam logic [2:0] PAL_BLUE    = 3'b001;
    localparam logic [2:0] PAL_BLACK   = 3'b000;

    function automatic logic [2:0] bar_colour(input bar_idx_t idx);
        logic [2:0] c;
        case (idx)
            3'd0:    c = PAL_WHITE;
            3'd1:    c = PAL_YELLOW;
            3'd2:    c = PAL_CYAN;
            3'd3:    c = PAL_GREEN;
            3'd4:    c = PAL_MAGENTA;
            3'd5:    c = PAL_RED;
            3'd6:    c = PAL_BLUE;
            default: c = PAL_BLACK;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/test_pattern_gen_bar_counter.sv
// Position/index counter pair that walks through fixed-width colour bars
// without a divider. The current index already reflects a load on the same
// cycle, so the first pixel of a line/frame sees the loaded value.
module bar_counter
    import tpg_pkg::*;
#(
    parameter int unsigned BAR_LEN = DEF_BAR_W,
    localparam int unsigned PW = (BAR_LEN > 1) ? $clog2(BAR_LEN) : 1
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          clr_i,
    input  logic          load_i,
    input  logic [PW-1:0] load_pos_i,
    input  bar_idx_t      load_idx_i,
    input  logic          adv_i,
    output bar_idx_t      idx_o
);

    logic [PW-1:0] pos_q, pos_d, cur_pos;
    bar_idx_t      idx_q, idx_d, cur_idx;

    // Select loaded or stored value, then step position with wrap into index.
    always_comb begin
        cur_pos = load_i ? load_pos_i : pos_q;
        cur_idx = load_i ? load_idx_i : idx_q;
        pos_d   = cur_pos;
        idx_d   = cur_idx;
        if (clr_i) begin
            pos_d = '0;
            idx_d = '0;
        end else if (adv_i) begin
            if (cur_pos == PW'(BAR_LEN - 1)) begin
                pos_d = '0;
                idx_d = cur_idx + bar_idx_t'(1);
            end else begin
                pos_d = cur_pos + PW'(1);
            end
        end
    end

    // Counter state register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            pos_q <= '0;
            idx_q <= '0;
        end else begin
            pos_q <= pos_d;
            idx_q <= idx_d;
        end
    end

    assign idx_o = cur_idx;

endmodule

// File: rtl/test_pattern_gen.sv
// Test pattern generator placed after lcd_sync. Produces colour bars,
// checkerboard, gradient or solid fills from the sync counters, with a
// two-stage output pipeline so R/G/B and DEN_OUT stay aligned.
module test_pattern_gen
    import tpg_pkg::*;
#(
    parameter int unsigned CW         = DEF_CW,
    parameter int unsigned H_OFFSET   = DEF_H_OFFSET,
    parameter int unsigned H_ACTIVE   = DEF_H_ACTIVE,
    parameter int unsigned V_OFFSET   = DEF_V_OFFSET,
    parameter int unsigned BAR_W      = DEF_BAR_W,
    parameter int unsigned BAR_H      = DEF_BAR_H,
    parameter int unsigned CHK_LOG2   = DEF_CHK_LOG2,
    parameter int unsigned SCROLL_DIV = DEF_SCROLL_DIV
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic [10:0]   COLUMNA,
    input  logic [9:0]    FILA,
    input  logic          DEN_IN,
    input  logic          VD_IN,
    input  logic [2:0]    MODE,
    input  logic          SCROLL_EN,
    output logic [CW-1:0] R,
    output logic [CW-1:0] G,
    output logic [CW-1:0] B,
    output logic          DEN_OUT
);

    localparam int unsigned HPW = (BAR_W > 1) ? $clog2(BAR_W) : 1;
    localparam int unsigned DW  = (SCROLL_DIV > 1) ? $clog2(SCROLL_DIV) : 1;

    logic            vd_q;
    logic            frame_start;
    tpg_mode_e       mode_q;
    logic            scroll_en_q;
    logic            scroll_en_now;
    logic            scroll_step;
    logic [DW-1:0]   div_q, div_d;
    logic [HPW-1:0]  scr_pos_q, scr_pos_d;
    bar_idx_t        scr_idx_q, scr_idx_d;
    logic [9:0]      fila_q;

    logic            h_load, h_adv, v_load, v_adv;
    bar_idx_t        h_idx, v_idx;

    logic [10:0]     col_off;
    logic [9:0]      row_off;
    logic            checker_on;
    logic [2:0]      flat_rgb;
    logic            use_grad;
    logic [CW-1:0]   grad;
    logic [CW-1:0]   pix_r_d, pix_g_d, pix_b_d;
    logic [CW-1:0]   pix_r_q, pix_g_q, pix_b_q;
    logic            den1_q;
    logic [CW-1:0]   r_q, g_q, b_q;
    logic            den_out_q;

    assign frame_start = vd_q & ~VD_IN;

    // The enable sampled on a frame start also governs the scroll step that
    // frame start triggers, so N enabled frame starts give one step per N.
    assign scroll_en_now = frame_start ? SCROLL_EN : scroll_en_q;

    // Frame-start scroll divider and scroll position/bar advance.
    always_comb begin
        div_d       = div_q;
        scr_pos_d   = scr_pos_q;
        scr_idx_d   = scr_idx_q;
        scroll_step = 1'b0;
        if (frame_start && scroll_en_now) begin
            if (div_q == DW'(SCROLL_DIV - 1)) begin
                div_d       = '0;
                scroll_step = 1'b1;
            end else begin
                div_d = div_q + DW'(1);
            end
        end
        if (scroll_step) begin
            if (scr_pos_q == HPW'(BAR_W - 1)) begin
                scr_pos_d = '0;
                scr_idx_d = scr_idx_q + bar_idx_t'(1);
            end else begin
                scr_pos_d = scr_pos_q + HPW'(1);
            end
        end
    end

    // Frame-level control state: sync edge history, latched mode and scroll.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            vd_q        <= 1'b0;
            fila_q      <= '0;
            mode_q      <= MODE_VBAR;
            scroll_en_q <= 1'b0;
            div_q       <= '0;
            scr_pos_q   <= '0;
            scr_idx_q   <= '0;
        end else begin
            vd_q      <= VD_IN;
            fila_q    <= FILA;
            div_q     <= div_d;
            scr_pos_q <= scr_pos_d;
            scr_idx_q <= scr_idx_d;
            if (frame_start) begin
                mode_q      <= tpg_mode_e'(MODE);
                scroll_en_q <= SCROLL_EN;
            end
        end
    end

    assign h_load = (COLUMNA == 11'(H_OFFSET));
    assign h_adv  = DEN_IN && (COLUMNA >= 11'(H_OFFSET)) &&
                    (COLUMNA < 11'(H_OFFSET + H_ACTIVE));
    assign v_load = (FILA == 10'(V_OFFSET));
    assign v_adv  = (FILA != fila_q) && (FILA > 10'(V_OFFSET));

    bar_counter #(
        .BAR_LEN (BAR_W)
    ) u_hbar (
        .clk_i      (CLK),
        .rst_i      (RST),
        .clr_i      (1'b0),
        .load_i     (h_load),
        .load_pos_i (scr_pos_q),
        .load_idx_i (scr_idx_q),
        .adv_i      (h_adv),
        .idx_o      (h_idx)
    );

    bar_counter #(
        .BAR_LEN (BAR_H)
    ) u_vbar (
        .clk_i      (CLK),
        .rst_i      (RST),
        .clr_i      (frame_start),
        .load_i     (v_load),
        .load_pos_i ('0),
        .load_idx_i ('0),
        .adv_i      (v_adv),
        .idx_o      (v_idx)
    );

    // Pattern selection for the pixel currently on COLUMNA/FILA.
    always_comb begin
        col_off    = COLUMNA - 11'(H_OFFSET);
        row_off    = FILA - 10'(V_OFFSET);
        // Checker square parity: white where column and row parities differ.
        checker_on = ((col_off >> CHK_LOG2) & 11'd1) != ((11'(row_off) >> CHK_LOG2) & 11'd1);
        grad       = CW'(col_off);
        flat_rgb   = PAL_BLACK;
        use_grad   = 1'b0;
        case (mode_q)
            MODE_VBAR:     flat_rgb = bar_colour(h_idx);
            MODE_HBAR:     flat_rgb = bar_colour(v_idx);
            MODE_CHECKER:  flat_rgb = checker_on ? PAL_WHITE : PAL_BLACK;
            MODE_GRADIENT: use_grad = 1'b1;
            MODE_WHITE:    flat_rgb = PAL_WHITE;
            default:       flat_rgb = PAL_BLACK;
        endcase
        pix_r_d = use_grad ? grad : {CW{flat_rgb[2]}};
        pix_g_d = use_grad ? grad : {CW{flat_rgb[1]}};
        pix_b_d = use_grad ? grad : {CW{flat_rgb[0]}};
    end

    // Two-stage output pipeline; blanking is applied in the second stage.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            pix_r_q   <= '0;
            pix_g_q   <= '0;
            pix_b_q   <= '0;
            den1_q    <= 1'b0;
            r_q       <= '0;
            g_q       <= '0;
            b_q       <= '0;
            den_out_q <= 1'b0;
        end else begin
            pix_r_q   <= pix_r_d;
            pix_g_q   <= pix_g_d;
            pix_b_q   <= pix_b_d;
            den1_q    <= DEN_IN;
            r_q       <= den1_q ? pix_r_q : '0;
            g_q       <= den1_q ? pix_g_q : '0;
            b_q       <= den1_q ? pix_b_q : '0;
            den_out_q <= den1_q;
        end
    end

    assign R       = r_q;
    assign G       = g_q;
    assign B       = b_q;
    assign DEN_OUT = den_out_q;

endmodule
